// File: rtl/rle_tx_arbiter.sv
// rle_tx_arbiter
// Two byte producers share one asynchronous serial transmit line. Each
// producer offers a byte with an active-low data-valid strobe. The arbiter
// grants round-robin, frames the winning byte (start, 8 data bits LSB first,
// optional even parity, stop) and shifts it out on txd. Each bit lasts
// BIT_CYCLES clocks.
//
// Optional feature: define RLE_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit. This gives an 11-bit frame.
//
// Parameters:
//   BIT_CYCLES  clocks per serial bit, 1..31
// Ports:
//   clock   in   rising-edge clock
//   reset_  in   asynchronous reset, active HIGH despite the trailing underscore
//   dav0_   in   requester 0 data valid, active low
//   byte0   in   requester 0 data, stable while dav0_ is low
//   dav1_   in   requester 1 data valid, active low
//   byte1   in   requester 1 data, stable while dav1_ is low
//   rfd0    out  ready-for-data to requester 0 (registered)
//   rfd1    out  ready-for-data to requester 1 (registered)
//   txd     out  serial line, idles marking (1), registered
//   busy    out  high whenever the arbiter is not idle
//   gnt     out  index of the requester currently or last served
module rle_tx_arbiter #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       dav0_,
  input  logic [7:0] byte0,
  input  logic       dav1_,
  input  logic [7:0] byte1,
  output logic       rfd0,
  output logic       rfd1,
  output logic       txd,
  output logic       busy,
  output logic       gnt
);

`ifdef RLE_TX_PARITY_EN
  localparam int BUF_W = 10;
  localparam logic [3:0] BITS_LOAD = 4'd10;
`else
  localparam int BUF_W = 9;
  localparam logic [3:0] BITS_LOAD = 4'd9;
`endif

  localparam logic [4:0] TIMER_LOAD = 5'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TX, REL} state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] buffer_q, buffer_d;
  logic [3:0]       bits_q, bits_d;
  logic [4:0]       timer_q, timer_d;
  logic             prio_q, prio_d;
  logic             gnt_q, gnt_d;
  logic             txd_q, txd_d;
  logic             rfd_q, rfd_d;

  logic             winner;
  logic [7:0]       win_byte;
  logic             rel_dav;

  // When both requesters are valid, the preferred requester (prio) wins.
  // Otherwise the single valid requester wins.
  assign winner   = (!dav0_ && !dav1_) ? prio_q : dav0_;
  assign win_byte = winner ? byte1 : byte0;
  assign rel_dav  = gnt_q ? dav1_ : dav0_;

  // All state and the registered outputs are loaded from the next-state logic.
  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      state_q  <= IDLE;
      buffer_q <= '1;
      bits_q   <= '0;
      timer_q  <= '0;
      prio_q   <= 1'b0;
      gnt_q    <= 1'b0;
      txd_q    <= 1'b1;
      rfd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      buffer_q <= buffer_d;
      bits_q   <= bits_d;
      timer_q  <= timer_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      txd_q    <= txd_d;
      rfd_q    <= rfd_d;
    end
  end

  // Next-state logic. The buffer carries the stop bit (and parity) above the
  // data byte. Ones are shifted in from the top, so once every bit has been
  // sent the line is left marking.
  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    bits_d   = bits_q;
    timer_d  = timer_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    txd_d    = txd_q;
    rfd_d    = rfd_q;
    unique case (state_q)
      IDLE: begin
        if (!dav0_ || !dav1_) begin
`ifdef RLE_TX_PARITY_EN
          buffer_d = {1'b1, ^win_byte, win_byte};
`else
          buffer_d = {1'b1, win_byte};
`endif
          txd_d   = 1'b0;
          bits_d  = BITS_LOAD;
          timer_d = TIMER_LOAD;
          gnt_d   = winner;
          rfd_d   = 1'b0;
          state_d = TX;
        end
      end
      TX: begin
        if (timer_q != 5'd0) begin
          timer_d = timer_q - 5'd1;
        end else if (bits_q != 4'd0) begin
          txd_d    = buffer_q[0];
          buffer_d = {1'b1, buffer_q[BUF_W-1:1]};
          bits_d   = bits_q - 4'd1;
          timer_d  = TIMER_LOAD;
        end else begin
          txd_d   = 1'b1;
          state_d = REL;
        end
      end
      REL: begin
        // Wait for the served requester to drop its request. Then the other
        // requester is preferred on the next acceptance.
        if (rel_dav) begin
          rfd_d   = 1'b1;
          prio_d  = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rfd0 = rfd_q;
  assign rfd1 = rfd_q;
  assign txd  = txd_q;
  assign gnt  = gnt_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rle_tx_arbiter.sv
// tb_rle_tx_arbiter
// Directed bench for rle_tx_arbiter. A table of request patterns is applied
// in order. Each entry names the expected winner and byte. The serial frame
// is sampled every clock and compared with a frame built from the expected
// byte. Hand-written sequences cover the following cases:
//   - reset asserted mid-frame
//   - reset asserted during a pending acceptance
module tb_rle_tx_arbiter;

`ifdef RLE_TX_PARITY_EN
  localparam int BC    = 2;
  localparam int NBITS = 11;
`else
  localparam int BC    = 4;
  localparam int NBITS = 10;
`endif
  localparam int NSAMP = NBITS * BC;

  logic       clock = 1'b0;
  logic       reset_ = 1'b1;
  logic       dav0_ = 1'b1;
  logic       dav1_ = 1'b1;
  logic [7:0] byte0 = 8'h00;
  logic [7:0] byte1 = 8'h00;
  logic       rfd0, rfd1, txd, busy, gnt;

  int tests_run = 0;
  int tests_failed = 0;

  rle_tx_arbiter #(.BIT_CYCLES(BC)) dut (
    .clock (clock),
    .reset_(reset_),
    .dav0_ (dav0_),
    .byte0 (byte0),
    .dav1_ (dav1_),
    .byte1 (byte1),
    .rfd0  (rfd0),
    .rfd1  (rfd1),
    .txd   (txd),
    .busy  (busy),
    .gnt   (gnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       d0;
    logic       d1;
    logic [7:0] b0;
    logic [7:0] b1;
    int         hold;
    logic       exp_gnt;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[13];

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic d0, input logic d1,
                                input logic [7:0] b0, input logic [7:0] b1);
    dav0_ = d0;
    dav1_ = d1;
    byte0 = b0;
    byte1 = b1;
  endtask

  // Waits for acceptance and samples the whole frame clock by clock. Then it
  // checks the release phase, keeping the winner's request low for 'hold'
  // clocks first.
  task automatic run_transfer(input string tag, input logic exp_gnt,
                              input logic [7:0] exp_byte, input int hold);
    logic [63:0] rx;
    logic [63:0] expf;
    logic [10:0] fbits;
    logic        seen;
    logic        stay_ok;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    check_output({tag, " accept"}, 64'(seen), 64'd1);
    if (!seen) return;
    check_output({tag, " gnt"}, 64'(gnt), 64'(exp_gnt));
    check_output({tag, " rfd low"}, 64'({rfd0, rfd1}), 64'd0);
`ifdef RLE_TX_PARITY_EN
    fbits = {1'b1, ^exp_byte, exp_byte, 1'b0};
`else
    fbits = {2'b11, exp_byte, 1'b0};
`endif
    rx   = '0;
    expf = '0;
    for (int i = 0; i < NSAMP; i++) begin
      if (i > 0) @(negedge clock);
      rx[i]   = txd;
      expf[i] = fbits[i / BC];
    end
    check_output({tag, " frame"}, rx, expf);
    @(negedge clock);
    check_output({tag, " rel"}, 64'({busy, txd, rfd0, rfd1}), 64'b1100);
    stay_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      if ({busy, txd, rfd0, rfd1} !== 4'b1100) stay_ok = 1'b0;
    end
    if (hold > 0) check_output({tag, " hold rel"}, 64'(stay_ok), 64'd1);
    if (exp_gnt) dav1_ = 1'b1;
    else dav0_ = 1'b1;
    @(negedge clock);
    check_output({tag, " released"}, 64'({rfd0, rfd1, busy}), 64'b110);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen;
    vecs[0]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 0,  1'b0, 8'hA5};
    vecs[1]  = '{1'b1, 1'b0, 8'hA5, 8'h07, 0,  1'b1, 8'h07};
    vecs[2]  = '{1'b0, 1'b0, 8'h11, 8'h22, 0,  1'b0, 8'h11};
    vecs[3]  = '{1'b1, 1'b0, 8'h11, 8'h22, 0,  1'b1, 8'h22};
    vecs[4]  = '{1'b0, 1'b0, 8'h01, 8'h80, 0,  1'b0, 8'h01};
    vecs[5]  = '{1'b0, 1'b0, 8'h02, 8'h80, 0,  1'b1, 8'h80};
    vecs[6]  = '{1'b0, 1'b0, 8'h02, 8'h81, 0,  1'b0, 8'h02};
    vecs[7]  = '{1'b0, 1'b0, 8'h03, 8'h81, 0,  1'b1, 8'h81};
    vecs[8]  = '{1'b0, 1'b0, 8'h03, 8'h82, 0,  1'b0, 8'h03};
    vecs[9]  = '{1'b0, 1'b0, 8'h04, 8'h82, 0,  1'b1, 8'h82};
    vecs[10] = '{1'b0, 1'b1, 8'hFF, 8'h82, 20, 1'b0, 8'hFF};
    vecs[11] = '{1'b1, 1'b0, 8'hFF, 8'h00, 0,  1'b1, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 8'h5A, 8'h00, 0,  1'b0, 8'h5A};

    repeat (2) @(negedge clock);
    check_output("reset values", 64'({txd, rfd0, rfd1, busy, gnt}), 64'b11100);
    reset_ = 1'b0;

    foreach (vecs[v]) begin
      apply_stimulus(vecs[v].d0, vecs[v].d1, vecs[v].b0, vecs[v].b1);
      run_transfer($sformatf("vec%0d", v), vecs[v].exp_gnt, vecs[v].exp_byte, vecs[v].hold);
    end

    // Reset pulse during data bit 3 of a requester-1 frame (prio is 1 here).
    apply_stimulus(1'b1, 1'b0, 8'h5A, 8'hC3);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("midframe accept", 64'(seen), 64'd1);
    repeat (4 * BC + 1) @(negedge clock);
    #2 reset_ = 1'b1;
    #1 check_output("async reset", 64'({txd, rfd0, rfd1, busy, gnt}), 64'b11100);
    // Both requesters valid while reset is held across an edge. No byte may be taken.
    apply_stimulus(1'b0, 1'b0, 8'h66, 8'hC3);
    @(posedge clock);
    @(negedge clock);
    check_output("reset beats accept", 64'({busy, txd}), 64'b01);
    #1 reset_ = 1'b0;
    run_transfer("post reset r0", 1'b0, 8'h66, 0);
    run_transfer("post reset r1", 1'b1, 8'hC3, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rle_tx_arbiter.md
# rle_tx_arbiter

- Shares one asynchronous serial transmit line between two byte producers, e.g. two run-length line encoders.
- Each producer offers a byte through its own dav_/rfd handshake.
- The arbiter grants round-robin, frames the granted byte (start, 8 data LSB first, stop) and shifts it out on txd at a fixed bit time.
- Sits between the encoders and the serial output pin; replaces per-encoder transmit logic.

## Interface
- BIT_CYCLES, default 4, clock cycles per serial bit; legal range 1..31.
- clock  input  1  sole clock, rising-edge.
- reset_  input  1  asynchronous, active-high: asserted when 1, despite the trailing underscore.
- dav0_  input  1  requester 0 data valid, active-low.
- byte0  input  8  requester 0 data, stable while dav0_=0.
- dav1_  input  1  requester 1 data valid, active-low.
- byte1  input  8  requester 1 data, stable while dav1_=0.
- rfd0  output  1  ready-for-data to requester 0, registered.
- rfd1  output  1  ready-for-data to requester 1, registered.
- txd  output  1  serial line, registered, marking=1.
- busy  output  1  1 whenever state≠IDLE.
- gnt  output  1  index of requester currently or last served.

## Operation
- Reset values: rfd0=rfd1=1, txd=1, busy=0, gnt=0, PRIO=0, state IDLE. All are forced immediately on reset_=1, including mid-frame.
- Registers:
  - BUFFER: 9 bits, 10 with parity.
  - BITS: 4 bits, remaining bits to send.
  - TIMER: 5 bits.
  - PRIO: 1 bit, preferred requester.
  - gnt.
- IDLE (rfd0=rfd1=1), behaviour at a rising edge:
  - If neither dav_ is low: stay in IDLE.
  - If exactly one dav_ is low: that requester wins.
  - If both are low: requester PRIO wins.
  - On acceptance:
    - BUFFER<={1, byteW}.
    - txd<=0 (start bit).
    - BITS<=9.
    - TIMER<=BIT_CYCLES-1.
    - gnt<=W.
    - rfd0<=0 and rfd1<=0.
    - Next state TX.
- TX, behaviour at each edge:
  - If TIMER≠0: TIMER<=TIMER-1.
  - Else if BITS≠0:
    - txd<=BUFFER[0].
    - BUFFER<={1, BUFFER[top:1]}.
    - BITS<=BITS-1.
    - TIMER<=BIT_CYCLES-1.
  - Else: next state REL, with txd held at 1.
- REL: waits for dav_ of gnt to be sampled 1. On that edge:
  - rfd0<=1 and rfd1<=1.
  - PRIO<=~gnt.
  - Next state IDLE.
- Loser handling:
  - The losing requester keeps dav_ low and is served on the next IDLE acceptance.
  - Round-robin guarantees it wins that acceptance.
- dav_ edges from either requester outside IDLE/REL are ignored; no byte is latched outside IDLE.

## Timing
- Acceptance edge to first start-bit cycle: 0.
  - txd changes on the acceptance edge.
- Each bit is held exactly BIT_CYCLES clocks.
- Frame length:
  - 10·BIT_CYCLES clocks without parity.
  - 11·BIT_CYCLES clocks with parity.
- TX→REL occurs on the edge that ends the stop bit.
- rfd rises 1 clock after winner dav_ is sampled high in REL.
  - If dav_ was already high on entering REL, rfd rises on the first REL edge.
- Minimum spacing between accepted bytes: frame length + 2 clocks.
- BIT_CYCLES=1: TIMER is always 0; one bit per clock.
- Simultaneous reset_ and acceptance: reset wins, no byte latched.

## Configuration
- RLE_TX_PARITY_EN defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit.
  - BUFFER is 10 bits; BITS loads 10.
  - Frame is 11 bits.
- Undefined: 10-bit frame, no parity logic present.

## Test plan
- Single byte, BIT_CYCLES=4, byte0=8'hA5, dav0_ low:
  - txd = 0 ×4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then 1.
  - busy=1 for 40 clocks plus REL.
  - rfd0 rises 1 clock after dav0_ goes high.
- After reset, dav0_ and dav1_ low on the same edge, byte0=8'h11, byte1=8'h22:
  - 0x11 sent first with gnt=0.
  - Then 0x22 with gnt=1, started on the first IDLE edge after requester 0 releases.
- Both requesters re-request immediately after every release, 6 bytes: gnt sequence 0,1,0,1,0,1; no byte duplicated or lost.
- Winner holds dav0_ low 20 clocks past stop bit: state stays REL, rfd0=rfd1=0, txd=1, no second frame.
- reset_ pulsed during data bit 3 of a frame:
  - txd=1, rfd0=rfd1=1, busy=0 without waiting for a clock edge.
  - A new request is then served from a fresh start bit with PRIO=0.
- With RLE_TX_PARITY_EN, byte1=8'h07, BIT_CYCLES=2:
  - Parity bit=1 after data bit 7.
  - Frame lasts 22 clocks.
